// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the Wishbone-to-Hyperbus FIFO bridge.
// State encoding is one-hot so busy and the wait-state decode are single-bit terms.
package hyperbus_pkg;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_RD_WAIT = 6'b000010,
    S_WR_WAIT = 6'b000100,
    S_RMW_RD  = 6'b001000,
    S_RMW_WR  = 6'b010000,
    S_RESP    = 6'b100000
  } state_t;

  localparam logic       CMD_READ  = 1'b0;
  localparam logic       CMD_WRITE = 1'b1;
  localparam logic [3:0] SEL_FULL  = 4'hF;

  // Per-lane select: lanes enabled in sel take the new data, the rest keep the old word.
  function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                             input logic [31:0] new_dat,
                                             input logic [31:0] old_dat);
    logic [31:0] merged;
    merged = old_dat;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_dat[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/hyperbus_req_timer.sv
// Request timeout counter plus a count of completions still owed by timed-out requests.
// An accepted completion in the expiry cycle wins, so expired is masked by done.
module hyperbus_req_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STALE_WIDTH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic done,
  input  logic stale_drop,
  output logic expired,
  output logic stale_nz
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]          LIMIT     = CW'(TIMEOUT_CYCLES);
  localparam logic [STALE_WIDTH-1:0] STALE_MAX = '1;

  logic [CW-1:0]          count;
  logic [STALE_WIDTH-1:0] stale;

  assign expired  = (TIMEOUT_CYCLES != 0) && active && !start && !done && (count == LIMIT);
  assign stale_nz = (stale != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      stale <= '0;
    end else begin
      // The request-pulse cycle is the first counted wait cycle.
      if (start) count <= CW'(1);
      else if (active && (count != LIMIT)) count <= count + 1'b1;

      if (expired && !stale_drop) begin
        if (stale != STALE_MAX) stale <= stale + 1'b1;
      end else if (stale_drop && !expired) begin
        stale <= stale - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave issuing single-word requests to the Hyperbus FIFO interface.
// Partial writes become read-modify-write; lost completions are covered by a timeout.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for cyc&stb
// S_RD_WAIT | read issued, waiting for rx_valid (data) or timeout
// S_WR_WAIT | full write issued, waiting for rx_valid (ack) or timeout
// S_RMW_RD  | old word read issued for a partial write
// S_RMW_WR  | merged word written, waiting for rx_valid or timeout
// S_RESP    | one-cycle ack/err to the master, request not re-sampled
module hyperbus_wb_bridge
  import hyperbus_pkg::*;
#(
  parameter int WB_ADDR_WIDTH   = 32,
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int STALE_WIDTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]      wb_dat_i,
  output logic [DATA_WIDTH-1:0]      wb_dat_o,
  input  logic [3:0]                 wb_sel_i,
  input  logic                       wb_we_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       rrq,
  output logic                       wrq,
  output logic [HBUS_ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0]      tx_dat_o,
  input  logic [DATA_WIDTH-1:0]      rx_dat_i,
  input  logic                       rx_valid,
  output logic                       busy
);

  state_t          state;
  logic            aborted;
  logic            abort_now;
  logic            waiting;
  logic            done;
  logic            expired;
  logic            stale_nz;
  logic [3:0]      sel_q;
  logic [DATA_WIDTH-1:0] wdat_q;

  assign waiting   = state inside {S_RD_WAIT, S_WR_WAIT, S_RMW_RD, S_RMW_WR};
  assign done      = rx_valid && !stale_nz && waiting;
  assign abort_now = aborted || !wb_cyc_i;
  assign busy      = (state != S_IDLE);

  hyperbus_req_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .STALE_WIDTH    (STALE_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (rrq | wrq),
    .active     (waiting),
    .done       (done),
    .stale_drop (rx_valid && stale_nz),
    .expired    (expired),
    .stale_nz   (stale_nz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rrq      <= 1'b0;
      wrq      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      adr_o    <= '0;
      tx_dat_o <= '0;
      wb_dat_o <= '0;
      aborted  <= 1'b0;
      sel_q    <= '0;
      wdat_q   <= '0;
    end else begin
      rrq      <= 1'b0;
      wrq      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (waiting && !wb_cyc_i) aborted <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            aborted <= 1'b0;
            sel_q   <= wb_sel_i;
            wdat_q  <= wb_dat_i;
            if ((wb_adr_i[1:0] != 2'b00) || (wb_sel_i == 4'h0)) begin
              wb_err_o <= 1'b1;
              state    <= S_RESP;
            end else if (wb_we_i == CMD_READ) begin
              rrq   <= 1'b1;
              adr_o <= HBUS_ADDR_WIDTH'(wb_adr_i >> 1);
              state <= S_RD_WAIT;
            end else if (wb_sel_i == SEL_FULL) begin
              wrq      <= 1'b1;
              adr_o    <= HBUS_ADDR_WIDTH'(wb_adr_i >> 1);
              tx_dat_o <= wb_dat_i;
              state    <= S_WR_WAIT;
            end else begin
              rrq   <= 1'b1;
              adr_o <= HBUS_ADDR_WIDTH'(wb_adr_i >> 1);
              state <= S_RMW_RD;
            end
          end
        end

        S_RD_WAIT: begin
          if (done) begin
            if (abort_now) state <= S_IDLE;
            else begin
              wb_dat_o <= rx_dat_i;
              wb_ack_o <= 1'b1;
              state    <= S_RESP;
            end
          end else if (expired) begin
            if (abort_now) state <= S_IDLE;
            else begin
              wb_err_o <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_WR_WAIT, S_RMW_WR: begin
          if (done) begin
            if (abort_now) state <= S_IDLE;
            else begin
              wb_ack_o <= 1'b1;
              state    <= S_RESP;
            end
          end else if (expired) begin
            if (abort_now) state <= S_IDLE;
            else begin
              wb_err_o <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_RMW_RD: begin
          // An aborted master gets no write: the old word stays untouched.
          if (done) begin
            if (abort_now) state <= S_IDLE;
            else begin
              tx_dat_o <= byte_merge(sel_q, wdat_q, rx_dat_i);
              wrq      <= 1'b1;
              state    <= S_RMW_WR;
            end
          end else if (expired) begin
            if (abort_now) state <= S_IDLE;
            else begin
              wb_err_o <= 1'b1;
              state    <= S_RESP;
            end
          end
        end

        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed bench for hyperbus_wb_bridge: vector table of single transactions
// plus hand sequences for stale completions, reset and master abort.
module tb_hyperbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
  logic        rrq, wrq, rx_valid, busy;
  logic [31:0] adr_o, tx_dat_o, rx_dat_i;

  always #5 clk = ~clk;

  hyperbus_wb_bridge #(
    .WB_ADDR_WIDTH(32), .HBUS_ADDR_WIDTH(32), .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16), .STALE_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .rrq(rrq), .wrq(wrq), .adr_o(adr_o), .tx_dat_o(tx_dat_o),
    .rx_dat_i(rx_dat_i), .rx_valid(rx_valid), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;
    logic        respond;
    logic [31:0] rd_word;
    int          e_nr;
    int          e_nw;
    logic [31:0] e_adr;
    logic [31:0] e_tx;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_rdat;
    int          e_cyc;
  } vec_t;

  vec_t vecs[11];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_adr"},  adr_o, 32'h0);
    chk({tag, "_tx"},   tx_dat_o, 32'h0);
    chk({tag, "_rdat"}, wb_dat_o, 32'h0);
    chk({tag, "_ctl"},  {27'h0, wb_ack_o, wb_err_o, rrq, wrq, busy}, 32'h0);
  endtask

  // Drives one Wishbone cycle and answers every rrq/wrq pulse with a
  // rx_valid 'dly' cycles later (read data for rrq, zero for wrq).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int dly, input logic respond,
                         input logic [31:0] rd_word,
                         output int n_r, output int n_w, output logic [31:0] o_adr,
                         output logic [31:0] o_tx, output logic o_ack, output logic o_err,
                         output logic [31:0] o_rdat, output int o_cyc, output logic o_both,
                         output logic [2:0] o_after);
    int pc;
    pc = -1000;
    n_r = 0; n_w = 0; o_adr = 32'h0; o_tx = 32'h0; o_ack = 1'b0; o_err = 1'b0;
    o_rdat = 32'h0; o_cyc = -1; o_both = 1'b0;
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if ((rrq && wrq) || (wb_ack_o && wb_err_o)) o_both = 1'b1;
      if (rrq || wrq) begin pc = i; o_adr = adr_o; end
      if (rrq) n_r++;
      if (wrq) begin n_w++; o_tx = tx_dat_o; end
      if (wb_ack_o || wb_err_o) begin
        o_ack = wb_ack_o; o_err = wb_err_o; o_rdat = wb_dat_o; o_cyc = i;
        break;
      end
      rx_valid = respond && (i == pc + dly);
      rx_dat_i = rx_valid ? ((n_w > 0) ? 32'h0 : rd_word) : 32'h0;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rx_valid = 1'b0; rx_dat_i = 32'h0;
    tick();
    o_after = {wb_ack_o, wb_err_o, busy};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_r, n_w, cyc, nw_acc, ack_at;
    logic [31:0] g_adr, g_tx, g_rdat;
    logic g_ack, g_err, g_both, acc, bsy3;
    logic [2:0] g_after;

    //        we    adr           dat           sel   dly rsp  rd_word       nr nw e_adr       e_tx          ack   err   e_rdat        cyc
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 5,  1'b1, 32'h0,        0, 1, 32'h80,     32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        7};
    vecs[1]  = '{1'b0, 32'h0000_0200, 32'h0,        4'hF, 3,  1'b1, 32'h12345678, 1, 0, 32'h100,    32'h0,        1'b1, 1'b0, 32'h12345678, 5};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'hAAAABBBB, 4'h3, 2,  1'b1, 32'h11223344, 1, 1, 32'h20,     32'h1122BBBB, 1'b1, 1'b0, 32'h0,        7};
    vecs[3]  = '{1'b1, 32'h0000_1000, 32'hA1B2C3D4, 4'hA, 1,  1'b1, 32'h55667788, 1, 1, 32'h800,    32'hA166C388, 1'b1, 1'b0, 32'h0,        5};
    vecs[4]  = '{1'b0, 32'h0000_000C, 32'h0,        4'hF, 0,  1'b1, 32'hCAFEF00D, 1, 0, 32'h6,      32'h0,        1'b1, 1'b0, 32'hCAFEF00D, 2};
    vecs[5]  = '{1'b0, 32'h0000_0200, 32'h0,        4'hF, 16, 1'b1, 32'h600DF00D, 1, 0, 32'h100,    32'h0,        1'b1, 1'b0, 32'h600DF00D, 18};
    vecs[6]  = '{1'b0, 32'h0000_0204, 32'h0,        4'hF, 15, 1'b1, 32'h13579BDF, 1, 0, 32'h102,    32'h0,        1'b1, 1'b0, 32'h13579BDF, 17};
    vecs[7]  = '{1'b0, 32'h0000_0102, 32'h0,        4'hF, 1,  1'b1, 32'h0,        0, 0, 32'h0,      32'h0,        1'b0, 1'b1, 32'h0,        1};
    vecs[8]  = '{1'b1, 32'h0000_0104, 32'h12345678, 4'h0, 1,  1'b1, 32'h0,        0, 0, 32'h0,      32'h0,        1'b0, 1'b1, 32'h0,        1};
    vecs[9]  = '{1'b1, 32'h0000_0003, 32'h12345678, 4'hF, 1,  1'b1, 32'h0,        0, 0, 32'h0,      32'h0,        1'b0, 1'b1, 32'h0,        1};
    vecs[10] = '{1'b0, 32'h0000_0300, 32'h0,        4'hF, 0,  1'b0, 32'h0,        1, 0, 32'h180,    32'h0,        1'b0, 1'b1, 32'h0,        18};

    rst = 1'b1; wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rx_valid = 1'b0; rx_dat_i = 32'h0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int k = 0; k < 11; k++) begin
      run_txn(vecs[k].we, vecs[k].adr, vecs[k].dat, vecs[k].sel, vecs[k].dly, vecs[k].respond,
              vecs[k].rd_word, n_r, n_w, g_adr, g_tx, g_ack, g_err, g_rdat, cyc, g_both, g_after);
      chk($sformatf("v%0d_nrrq", k), n_r, vecs[k].e_nr);
      chk($sformatf("v%0d_nwrq", k), n_w, vecs[k].e_nw);
      chk($sformatf("v%0d_ack", k), {31'h0, g_ack}, {31'h0, vecs[k].e_ack});
      chk($sformatf("v%0d_err", k), {31'h0, g_err}, {31'h0, vecs[k].e_err});
      chk($sformatf("v%0d_resp_cycle", k), cyc, vecs[k].e_cyc);
      chk($sformatf("v%0d_exclusive", k), {31'h0, g_both}, 32'h0);
      chk($sformatf("v%0d_after", k), {29'h0, g_after}, 32'h0);
      if (vecs[k].e_nr + vecs[k].e_nw > 0) chk($sformatf("v%0d_adr", k), g_adr, vecs[k].e_adr);
      if (vecs[k].e_nw > 0) chk($sformatf("v%0d_tx", k), g_tx, vecs[k].e_tx);
      if (!vecs[k].we && vecs[k].e_ack) chk($sformatf("v%0d_rdat", k), g_rdat, vecs[k].e_rdat);
    end

    // Late completion of the timed-out read arrives while idle and is dropped.
    rx_valid = 1'b1; rx_dat_i = 32'hBADBAD00;
    tick();
    rx_valid = 1'b0; rx_dat_i = 32'h0;
    chk("stale_idle_quiet", {29'h0, wb_ack_o, wb_err_o, busy}, 32'h0);
    run_txn(1'b0, 32'h400, 32'h0, 4'hF, 2, 1'b1, 32'h0F0F0F0F,
            n_r, n_w, g_adr, g_tx, g_ack, g_err, g_rdat, cyc, g_both, g_after);
    chk("post_stale_ack", {31'h0, g_ack}, 32'h1);
    chk("post_stale_rdat", g_rdat, 32'h0F0F0F0F);
    chk("post_stale_cycle", cyc, 4);

    // Another timeout, then its late completion lands inside the next read's wait.
    run_txn(1'b0, 32'h480, 32'h0, 4'hF, 0, 1'b0, 32'h0,
            n_r, n_w, g_adr, g_tx, g_ack, g_err, g_rdat, cyc, g_both, g_after);
    chk("timeout2_err", {31'h0, g_err}, 32'h1);
    wb_we_i = 1'b0; wb_adr_i = 32'h900; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    g_ack = 1'b0; g_rdat = 32'h0; ack_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (wb_ack_o || wb_err_o) begin
        g_ack = wb_ack_o; g_rdat = wb_dat_o; ack_at = i;
        break;
      end
      rx_valid = (i == 2) || (i == 4);
      rx_dat_i = (i == 2) ? 32'hDEAD0000 : 32'h5A5A1234;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rx_valid = 1'b0; rx_dat_i = 32'h0;
    tick();
    chk("stale_wait_ack", {31'h0, g_ack}, 32'h1);
    chk("stale_wait_rdat", g_rdat, 32'h5A5A1234);
    chk("stale_wait_cycle", ack_at, 5);

    // Reset in the middle of a read wait.
    wb_we_i = 1'b0; wb_adr_i = 32'h500; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    chk("rst_seq_rrq", {31'h0, rrq}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = acc | wb_ack_o | wb_err_o | rrq | wrq;
    end
    chk("midrst_quiet", {31'h0, acc}, 32'h0);
    run_txn(1'b0, 32'h600, 32'h0, 4'hF, 1, 1'b1, 32'h89ABCDEF,
            n_r, n_w, g_adr, g_tx, g_ack, g_err, g_rdat, cyc, g_both, g_after);
    chk("postrst_rdat", g_rdat, 32'h89ABCDEF);
    chk("postrst_cycle", cyc, 3);

    // Master drops cyc during a read wait: completion absorbed, no response.
    wb_we_i = 1'b0; wb_adr_i = 32'h700; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    chk("abort_rd_rrq", {31'h0, rrq}, 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acc = 1'b0; bsy3 = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      acc = acc | wb_ack_o | wb_err_o;
      if (i == 3) bsy3 = busy;
      rx_valid = (i == 3);
      rx_dat_i = (i == 3) ? 32'h77777777 : 32'h0;
    end
    rx_valid = 1'b0;
    chk("abort_rd_still_busy", {31'h0, bsy3}, 32'h1);
    chk("abort_rd_no_resp", {31'h0, acc}, 32'h0);
    chk("abort_rd_idle", {31'h0, busy}, 32'h0);

    // Abort during the read half of a read-modify-write: no write is issued.
    wb_we_i = 1'b1; wb_adr_i = 32'h800; wb_dat_i = 32'h000000FF; wb_sel_i = 4'h1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    chk("abort_rmw_rrq", {31'h0, rrq}, 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acc = 1'b0; nw_acc = 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      acc = acc | wb_ack_o | wb_err_o;
      if (wrq) nw_acc++;
      rx_valid = (i == 2);
      rx_dat_i = (i == 2) ? 32'h11111111 : 32'h0;
    end
    rx_valid = 1'b0;
    chk("abort_rmw_no_wrq", nw_acc, 0);
    chk("abort_rmw_no_resp", {31'h0, acc}, 32'h0);
    chk("abort_rmw_idle", {31'h0, busy}, 32'h0);

    run_txn(1'b1, 32'h900, 32'h01020304, 4'hF, 1, 1'b1, 32'h0,
            n_r, n_w, g_adr, g_tx, g_ack, g_err, g_rdat, cyc, g_both, g_after);
    chk("post_abort_ack", {31'h0, g_ack}, 32'h1);
    chk("post_abort_tx", g_tx, 32'h01020304);
    chk("post_abort_cycle", cyc, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
